// File: rtl/pps_timecode_tx.sv
// PPS pulse and serial timecode transmitter.
// After each accepted PPS flag, tc_o carries a fixed-width high pulse.
// Optionally a low gap and a 42-bit frame follow.
// The frame is: start 1, 32-bit second MSB first, 8-bit XOR checksum MSB first, stop 0.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line low, waiting for an enabled PPS flag
// S_PULSE | line high for PULSE_CYCLES
// S_GAP   | line low for GAP_CYCLES before the frame
// S_FRAME | shifting out the 42 frame bits, BIT_CYCLES each
module pps_timecode_tx #(
    parameter int PULSE_CYCLES = 1250,
    parameter int GAP_CYCLES   = 1250,
    parameter int BIT_CYCLES   = 125
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        en_i,
    input  logic        frame_en_i,
    input  logic        pps_flag_i,
    input  logic [31:0] cur_sec_i,
    output logic        tc_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [31:0] sent_sec_o,
    output logic [7:0]  overrun_count_o
);

    localparam int FRAME_BITS = 42;
    localparam int MAX_A      = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC    = (MAX_A > BIT_CYCLES) ? MAX_A : BIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYC + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_FRAME = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [FRAME_BITS-1:0] r_frame, w_frame_nxt;
    logic                  r_tc, w_tc_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [31:0]           r_sec, w_sec_nxt;
    logic [7:0]            r_ovr, w_ovr_nxt;

    logic [31:0]           w_sec_inc;
    logic [7:0]            w_chk;

    assign w_sec_inc = cur_sec_i + 32'd1;
    assign w_chk     = w_sec_inc[31:24] ^ w_sec_inc[23:16] ^ w_sec_inc[15:8] ^ w_sec_inc[7:0];

    // Next-state and next-output logic; disable beats a flag, a flag beats the running sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_frame_nxt = r_frame;
        w_tc_nxt    = r_tc;
        w_done_nxt  = 1'b0;
        w_sec_nxt   = r_sec;
        w_ovr_nxt   = r_ovr;

        if (!en_i) begin
            w_state_nxt = S_IDLE;
            w_tc_nxt    = 1'b0;
        end else if (pps_flag_i) begin
            if ((r_state != S_IDLE) && (r_ovr != 8'hFF)) begin
                w_ovr_nxt = r_ovr + 8'd1;
            end
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = PULSE_LD;
            w_tc_nxt    = 1'b1;
            w_sec_nxt   = w_sec_inc;
            w_frame_nxt = {1'b1, w_sec_inc, w_chk, 1'b0};
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tc_nxt = 1'b0;
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        w_tc_nxt = 1'b0;
                        if (frame_en_i) begin
                            w_state_nxt = S_GAP;
                            w_cnt_nxt   = GAP_LD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_FRAME;
                        w_cnt_nxt   = BIT_LD;
                        w_bit_nxt   = BIT_LAST;
                        w_tc_nxt    = r_frame[FRAME_BITS-1];
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_FRAME: begin
                    if (r_cnt == '0) begin
                        if (r_bit == '0) begin
                            w_state_nxt = S_IDLE;
                            w_tc_nxt    = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_bit_nxt   = r_bit - BIT_W'(1);
                            w_cnt_nxt   = BIT_LD;
                            w_frame_nxt = {r_frame[FRAME_BITS-2:0], 1'b0};
                            w_tc_nxt    = r_frame[FRAME_BITS-2];
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tc_nxt    = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= '0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sec   <= '0;
            r_ovr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_frame <= w_frame_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sec   <= w_sec_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign tc_o            = r_tc;
    assign busy_o          = r_busy;
    assign frame_done_o    = r_done;
    assign sent_sec_o      = r_sec;
    assign overrun_count_o = r_ovr;

endmodule

// File: tb/tb_pps_timecode_tx.sv
// Testbench for pps_timecode_tx.
// A timeline model predicts every output each cycle.
// The model tracks cycles elapsed since the last accepted flag.
module tb_pps_timecode_tx;

    localparam int P = 8;
    localparam int G = 4;
    localparam int B = 4;
    localparam int FRAME_END = P + G + 42 * B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fe = 1'b0;
    logic        pps = 1'b0;
    logic [31:0] cur = '0;
    logic        tc_o, busy_o, frame_done_o;
    logic [31:0] sent_sec_o;
    logic [7:0]  overrun_count_o;

    int n_chk = 0;
    int n_pass = 0;

    // model state
    bit          m_active = 0;
    int          m_t = 0;
    logic [31:0] m_sent = '0;
    int          m_ovr = 0;
    bit          m_done = 0;

    pps_timecode_tx #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .BIT_CYCLES(B)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .en_i(en),
        .frame_en_i(fe),
        .pps_flag_i(pps),
        .cur_sec_i(cur),
        .tc_o(tc_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .sent_sec_o(sent_sec_o),
        .overrun_count_o(overrun_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic exp_tc();
        int k;
        logic [7:0] c;
        if (!m_active) return 1'b0;
        if (m_t <= P) return 1'b1;
        if (m_t <= P + G) return 1'b0;
        k = (m_t - P - G - 1) / B;
        c = m_sent[31:24] ^ m_sent[23:16] ^ m_sent[15:8] ^ m_sent[7:0];
        if (k == 0) return 1'b1;
        if (k <= 32) return m_sent[32 - k];
        if (k <= 40) return c[40 - k];
        return 1'b0;
    endfunction

    function automatic logic [42:0] exp_vec();
        return {exp_tc(), logic'(m_active), logic'(m_done), m_sent, 8'(m_ovr)};
    endfunction

    function automatic logic [42:0] act_vec();
        return {tc_o, busy_o, frame_done_o, sent_sec_o, overrun_count_o};
    endfunction

    // Advance one clock; the model consumes the inputs as seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_sent = '0; m_ovr = 0; m_done = 0; m_t = 0;
        end else if (!en) begin
            m_active = 0; m_done = 0;
        end else if (pps) begin
            if (m_active && m_ovr < 255) m_ovr++;
            m_active = 1; m_t = 1; m_sent = cur + 32'd1; m_done = 0;
        end else if (m_active) begin
            m_done = 0;
            if (m_t == P && !fe) m_active = 0;
            else if (m_t == FRAME_END) begin m_active = 0; m_done = 1; end
            else m_t++;
        end else begin
            m_done = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; fe = 1; pps = 1; cur = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) tick();
        n_chk++;
        if (act_vec() !== 43'd0) $display("FAIL reset: got %h exp 0", act_vec());
        else n_pass++;
        rst = 0; pps = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_idle: got %h exp %h", act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_basic_frame();
        int done_cyc = -1;
        en = 1; fe = 1; cur = 32'h12345678;
        for (int i = 0; i < 190; i++) begin
            pps = (i == 0);
            tick();
            if (frame_done_o === 1'b1 && done_cyc < 0) done_cyc = i + 1;
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL basic_frame cyc %0d: got %h exp %h", i + 1, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0;
        n_chk++;
        if (sent_sec_o !== 32'h12345679) $display("FAIL basic_sent: got %h exp 12345679", sent_sec_o);
        else n_pass++;
        n_chk++;
        if (done_cyc != 181) $display("FAIL basic_done_cycle: got %0d exp 181", done_cyc);
        else n_pass++;
    endtask

    task automatic test_wrap_pulse_only();
        bit saw_done = 0;
        int busy_len = 0;
        en = 1; fe = 0; cur = 32'hFFFFFFFF;
        for (int i = 0; i < 20; i++) begin
            pps = (i == 0);
            tick();
            if (frame_done_o === 1'b1) saw_done = 1;
            if (busy_o === 1'b1) busy_len++;
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL pulse_only cyc %0d: got %h exp %h", i + 1, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0;
        n_chk++;
        if (sent_sec_o !== 32'h0) $display("FAIL wrap_sent: got %h exp 00000000", sent_sec_o);
        else n_pass++;
        n_chk++;
        if (saw_done || busy_len != P) $display("FAIL pulse_only_len: got done=%0d busy=%0d exp done=0 busy=%0d", saw_done, busy_len, P);
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit saw_done = 0;
        en = 1; fe = 1; cur = 32'hA5A5_0F0F;
        for (int i = 0; i < 300; i++) begin
            pps = (i == 0 || i == 93);
            if (i == 93) cur = 32'h0BAD_F00D;
            tick();
            if (i > 93 && frame_done_o === 1'b1) saw_done = 1;
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL overrun cyc %0d: got %h exp %h", i + 1, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0;
        n_chk++;
        if (overrun_count_o !== 8'd1 || !saw_done) $display("FAIL overrun_one: got cnt=%0d done=%0d exp cnt=1 done=1", overrun_count_o, saw_done);
        else n_pass++;
        for (int i = 0; i < 600; i++) begin
            pps = (i % 2 == 0);
            cur = $urandom;
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL overrun_sat cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0;
        n_chk++;
        if (overrun_count_o !== 8'd255) $display("FAIL overrun_saturate: got %0d exp 255", overrun_count_o);
        else n_pass++;
        for (int i = 0; i < 200; i++) tick();
    endtask

    task automatic test_disable();
        en = 1; fe = 1; cur = 32'h0000_1000;
        for (int i = 0; i < 30; i++) begin
            pps = (i == 0) || (i >= 15 && i < 20);
            en  = !(i >= 10 && i < 20);
            tick();
            if (i == 10) begin
                n_chk++;
                if (tc_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0)
                    $display("FAIL disable_gap: got tc=%b busy=%b done=%b exp 0 0 0", tc_o, busy_o, frame_done_o);
                else n_pass++;
            end
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL disable cyc %0d: got %h exp %h", i + 1, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0; en = 1;
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        en = 1; fe = 1; cur = 32'hCAFE_0001;
        for (int i = 0; i < 260; i++) begin
            pps = (i == 0 || i == 60);
            rst = (i == 50);
            tick();
            if (i == 50) begin
                n_chk++;
                if (act_vec() !== 43'd0) $display("FAIL reset_mid: got %h exp 0", act_vec());
                else n_pass++;
            end
            if (frame_done_o === 1'b1) saw_done = 1;
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_mid cyc %0d: got %h exp %h", i + 1, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0; rst = 0;
        n_chk++;
        if (!saw_done || sent_sec_o !== 32'hCAFE_0002) $display("FAIL reset_mid_frame: got done=%0d sent=%h exp done=1 sent=cafe0002", saw_done, sent_sec_o);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pps = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 199) != 0);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 49) == 0) fe = $urandom_range(0, 1);
            cur = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        pps = 0; rst = 0; en = 1;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_wrap_pulse_only();
        test_overrun();
        test_disable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
